// File: rtl/prog_rom.sv
// prog_rom: writable program memory answering the cpu instruction fetch.
// In RUN it returns mem[addr] combinationally. In LOAD an operator enters a
// program one word per push of wr_strobe, taking the word from wr_data.
// Ports:
//   clk, n_rst        clock (rising edge) and async active-low reset
//   addr, data        fetch address in, instruction word out (0 while loading)
//   load_req          push-button: enter LOAD from RUN, abort LOAD back to RUN
//   wr_strobe         push-button: write wr_data at wr_ptr while in LOAD
//   wr_data           word to write, from board switches
//   busy              high while in LOAD
//   wr_ptr            next address to be written
//   done              one-cycle pulse on the edge that leaves LOAD
module prog_rom #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    input  logic              load_req,
    input  logic              wr_strobe,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              done
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];

    // Two synchronizer flops plus a history flop per push-button.
    logic load_s1, load_s2, load_s3;
    logic strb_s1, strb_s2, strb_s3;
    logic load_pulse;
    logic strb_pulse;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            load_s1 <= 1'b0;
            load_s2 <= 1'b0;
            load_s3 <= 1'b0;
            strb_s1 <= 1'b0;
            strb_s2 <= 1'b0;
            strb_s3 <= 1'b0;
        end else begin
            load_s1 <= load_req;
            load_s2 <= load_s1;
            load_s3 <= load_s2;
            strb_s1 <= wr_strobe;
            strb_s2 <= strb_s1;
            strb_s3 <= strb_s2;
        end
    end

    // One-cycle pulse per rising edge of each synchronized button.
    assign load_pulse = load_s2 & ~load_s3;
    assign strb_pulse = strb_s2 & ~strb_s3;

    // Mode FSM, memory writes and registered status outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state  <= RUN;
            busy   <= 1'b0;
            done   <= 1'b0;
            wr_ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                RUN: begin
                    if (load_pulse) begin
                        state  <= LOAD;
                        busy   <= 1'b1;
                        wr_ptr <= '0;
                    end
                end
                LOAD: begin
                    if (strb_pulse) begin
                        mem[wr_ptr] <= wr_data;
                        wr_ptr      <= wr_ptr + ADDR_W'(1);
                    end
                    // Last-word write and abort share one exit, so a coincident
                    // strobe and abort still give a single done pulse.
                    if ((strb_pulse && (wr_ptr == LAST_ADDR)) || load_pulse) begin
                        state <= RUN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= RUN;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Zero-latency fetch; LOAD forces the harmless all-zero word.
    assign data = (state == LOAD) ? '0 : mem[addr];

endmodule

// File: tb/tb_prog_rom.sv
// tb_prog_rom: scoreboard bench for prog_rom (ADDR_W=4, DATA_W=4).
module tb_prog_rom;

    logic       clk;
    logic       n_rst;
    logic [3:0] addr;
    logic [3:0] data;
    logic       load_req;
    logic       wr_strobe;
    logic [3:0] wr_data;
    logic       busy;
    logic [3:0] wr_ptr;
    logic       done;

    int errors;
    int checks;
    int done_cnt;

    // Reference model of the memory and mode.
    logic [3:0] model_mem [16];
    logic       model_load;
    logic [3:0] model_ptr;
    logic [3:0] exp_q [$];

    prog_rom #(.ADDR_W(4), .DATA_W(4)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .addr      (addr),
        .data      (data),
        .load_req  (load_req),
        .wr_strobe (wr_strobe),
        .wr_data   (wr_data),
        .busy      (busy),
        .wr_ptr    (wr_ptr),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each negedge sample of done counts one cycle of the pulse.
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive addr, queue the model's answer, then compare what the DUT returns.
    task automatic read_check(input logic [3:0] a);
        logic [3:0] exp;
        logic [3:0] got_exp;
        addr = a;
        exp  = model_load ? 4'h0 : model_mem[a];
        exp_q.push_back(exp);
        #1;
        got_exp = exp_q.pop_front();
        check($sformatf("data@%0h", a), 32'(data), 32'(got_exp));
    endtask

    task automatic press_load();
        @(negedge clk);
        load_req = 1'b1;
        cycles(3);
        load_req = 1'b0;
        cycles(3);
        if (model_load) begin
            model_load = 1'b0;
        end else begin
            model_load = 1'b1;
            model_ptr  = 4'h0;
        end
    endtask

    task automatic press_write(input logic [3:0] d);
        @(negedge clk);
        wr_data   = d;
        wr_strobe = 1'b1;
        cycles(3);
        wr_strobe = 1'b0;
        cycles(3);
        model_mem[model_ptr] = d;
        if (model_ptr == 4'hF) model_load = 1'b0;
        model_ptr = model_ptr + 4'h1;
    endtask

    initial begin
        int d0;
        errors = 0;
        checks = 0;
        done_cnt = 0;
        model_load = 1'b0;
        model_ptr = 4'h0;
        for (int i = 0; i < 16; i++) model_mem[i] = 4'h0;
        n_rst = 1'b0;
        addr = 4'h0;
        load_req = 1'b0;
        wr_strobe = 1'b0;
        wr_data = 4'h0;

        // Reset state
        cycles(2);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ptr", 32'(wr_ptr), 32'd0);
        n_rst = 1'b1;
        cycles(2);
        for (int a = 0; a < 16; a++) read_check(4'(a));
        check("run_busy", 32'(busy), 32'd0);
        check("run_done", 32'(done), 32'd0);

        // Full program load 1..F,0
        press_load();
        check("enter_busy", 32'(busy), 32'd1);
        check("enter_ptr", 32'(wr_ptr), 32'd0);
        read_check(4'h3);
        d0 = done_cnt;
        for (int i = 0; i < 16; i++) begin
            press_write(4'(i + 1));
            if (i < 15) begin
                check($sformatf("load_busy%0d", i), 32'(busy), 32'd1);
                check($sformatf("load_ptr%0d", i), 32'(wr_ptr), 32'(i + 1));
            end
        end
        check("full_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("full_busy", 32'(busy), 32'd0);
        check("full_ptr", 32'(wr_ptr), 32'd0);
        for (int a = 0; a < 16; a++) read_check(4'(a));

        // Held strobe writes exactly once
        press_load();
        @(negedge clk);
        wr_data = 4'h5;
        wr_strobe = 1'b1;
        cycles(20);
        check("held_ptr", 32'(wr_ptr), 32'd1);
        read_check(4'h0);
        read_check(4'h9);
        wr_strobe = 1'b0;
        cycles(3);
        model_mem[0] = 4'h5;
        model_ptr = 4'h1;
        d0 = done_cnt;
        press_load();
        check("held_abort_done", 32'(done_cnt - d0), 32'd1);
        read_check(4'h0);
        read_check(4'h1);

        // Partial load then abort
        press_load();
        press_write(4'h1);
        press_write(4'h1);
        d0 = done_cnt;
        press_load();
        check("abort_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ptr_held", 32'(wr_ptr), 32'd2);
        read_check(4'h0);
        read_check(4'h1);
        read_check(4'h2);
        press_load();
        check("reentry_ptr", 32'(wr_ptr), 32'd0);

        // Coincident last write and abort
        for (int i = 0; i < 15; i++) press_write(4'hA);
        check("pre_last_ptr", 32'(wr_ptr), 32'd15);
        d0 = done_cnt;
        @(negedge clk);
        wr_data = 4'h1;
        wr_strobe = 1'b1;
        load_req = 1'b1;
        cycles(3);
        wr_strobe = 1'b0;
        load_req = 1'b0;
        cycles(3);
        model_mem[15] = 4'h1;
        model_ptr = 4'h0;
        model_load = 1'b0;
        check("coinc_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("coinc_busy", 32'(busy), 32'd0);
        check("coinc_ptr", 32'(wr_ptr), 32'd0);
        read_check(4'hF);
        read_check(4'hE);

        // Async reset mid-load
        press_load();
        for (int i = 0; i < 5; i++) press_write(4'h7);
        check("pre_rst_ptr", 32'(wr_ptr), 32'd5);
        @(negedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        check("async_busy", 32'(busy), 32'd0);
        check("async_ptr", 32'(wr_ptr), 32'd0);
        check("async_done", 32'(done), 32'd0);
        for (int i = 0; i < 16; i++) model_mem[i] = 4'h0;
        model_load = 1'b0;
        model_ptr = 4'h0;
        cycles(2);
        n_rst = 1'b1;
        cycles(2);
        for (int a = 0; a < 16; a++) read_check(4'(a));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_rom.md
Name: prog_rom

Overview:
- Program memory on the responder side of the cpu instruction-fetch interface.
- Returns the 4-bit instruction word for the cpu's `addr` on `data` each cycle.
- Includes a switch-driven load mode. An operator enters a program one word at a time with a push-button strobe, without resynthesis.
- Sits beside cpu at board top level. Its `data` output drives cpu `data`; cpu `addr` drives its `addr` input.

Parameters:
- ADDR_W, 4, address width. DEPTH = 2**ADDR_W words. The current cpu instantiates it with ADDR_W=1.
- DATA_W, 4, instruction word width.

Ports:
- clk  input  1  system clock, rising-edge active
- n_rst  input  1  asynchronous active-low reset
- addr  input  ADDR_W  fetch address from cpu program counter
- data  output  DATA_W  instruction word to cpu
- load_req  input  1  asynchronous push-button that enters or aborts load mode
- wr_strobe  input  1  asynchronous push-button that writes one word
- wr_data  input  DATA_W  word to write, from board switches; held stable by operator
- busy  output  1  high while in LOAD
- wr_ptr  output  ADDR_W  next address to be written
- done  output  1  one-cycle pulse when load mode exits

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, n_rst). While n_rst=0:
  - state=RUN
  - all memory words=0
  - wr_ptr=0, busy=0, done=0
  - all synchronizer flops=0
  - data=mem[addr]=0
- Input conditioning: load_req and wr_strobe each pass through a 2-flop synchronizer plus a third history flop.
  - Rising-edge pulse = s2 & ~s3.
  - Pulse is high for exactly one cycle, in the cycle after the 2nd rising clk edge that samples the input high.
  - The action occurs on the 3rd rising edge.
  - Input held high produces one pulse only; it must go low and return high for another.
- States RUN, LOAD.
- RUN:
  - data = mem[addr], combinational, zero-cycle latency, so cpu semantics are unchanged.
  - wr_strobe pulses are ignored.
  - load_req pulse -> LOAD; wr_ptr <= 0.
- LOAD:
  - busy=1.
  - data forced to 0 (the cpu "LED OFF" word), so the free-running cpu is harmless during loading.
  - wr_strobe pulse -> mem[wr_ptr] <= wr_data, sampled at that edge; wr_ptr <= wr_ptr+1.
  - Write to wr_ptr = DEPTH-1:
    - the word is written
    - wr_ptr wraps to 0
    - state -> RUN
    - done=1 for the next cycle
  - load_req pulse in LOAD (abort) -> RUN next edge, done pulse.
    - Words not yet written keep their prior contents.
    - wr_ptr holds its value (visible for debug) until the next LOAD entry clears it.
  - wr_strobe and load_req pulses in the same cycle: perform the write and pointer increment first, then exit to RUN. Only one done pulse results.
- busy falls on the same edge done rises.
- The first cycle back in RUN already shows mem[addr] on data.
- Reset mid-load: immediate return to the reset state. Memory is cleared; partial program lost.
- Width rules:
  - wr_ptr arithmetic is modulo DEPTH.
  - addr is never out of range, since DEPTH = 2**ADDR_W.
- No read/write hazard: reads are suppressed in LOAD.

Test Plan:
- Reset then RUN, addr=0..15 -> data=0 for every address; busy=0, done=0.
- Pulse load_req, write 16 words 0x1,0x2,…,0xF,0x0 via wr_strobe (strobe high 3 cycles, low 3 cycles) -> busy=1 throughout, wr_ptr steps 0..15. done pulses once after the 16th write and wr_ptr=0. Then addr=k reads back (k+1) mod 16.
- In LOAD with wr_strobe held high 20 cycles and wr_data=0x5 -> exactly one write: mem[0]=0x5, wr_ptr=1. While in LOAD, data=0 at any addr.
- Enter LOAD, write 0x1,0x1 to addr 0..1, pulse load_req -> done pulse, busy=0. addr0/1 read 0x1; addr2 keeps its prior value. Next LOAD entry restarts wr_ptr at 0.
- At wr_ptr=15, wr_strobe and load_req edges in the same cycle with wr_data=0x1 -> mem[15]=0x1, single done pulse, state RUN, wr_ptr=0.
- Assert n_rst=0 asynchronously mid-LOAD after 5 writes -> busy=0, wr_ptr=0, done=0 immediately, without waiting for a clk edge. All words read 0 after release.
